// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed little-endian byte stream and
// writes it word by word into instruction memory, holding the downstream
// core in reset until a load completes successfully.
// Optional feature macro: LOADER_CHECKSUM_EN adds an XOR trailer byte check.
module program_loader #(
    parameter int WORDS  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WAIT,
        DONE,
        ERROR
`ifdef LOADER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [15:0] words_rcvd;
    logic [1:0]  lane;
    logic [23:0] word_buf;
    logic        accept;
    logic        restart;
    logic        last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Handshake, length assembly and end-of-payload detection shared by both processes
    always_comb begin
        rx_ready   = (state == LEN0) || (state == LEN1) || (state == DATA);
`ifdef LOADER_CHECKSUM_EN
        rx_ready   = rx_ready || (state == CSUM);
`endif
        accept     = rx_valid && rx_ready;
        restart    = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
        len_full   = {rx_data, len_lo};
        last_byte  = (lane == 2'd3) && ((words_rcvd + 16'd1) == len);
        busy       = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == WAIT);
`ifdef LOADER_CHECKSUM_EN
        busy       = busy || (state == CSUM);
`endif
        done       = (state == DONE);
        err        = (state == ERROR);
        core_reset = (state != DONE);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = LEN0;
            LEN0:  if (accept) next_state = LEN1;
            LEN1: begin
                if (accept) begin
                    if (len_full > 16'(WORDS)) begin
                        next_state = ERROR;
                    end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = CSUM;
`else
                        next_state = DONE;
`endif
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA:  if (accept && last_byte) next_state = WAIT;
`ifdef LOADER_CHECKSUM_EN
            WAIT:  next_state = CSUM;
            CSUM:  if (accept) next_state = (rx_data == csum) ? DONE : ERROR;
`else
            WAIT:  next_state = DONE;
`endif
            DONE:  if (start) next_state = LEN0;
            ERROR: if (start) next_state = LEN0;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: length capture, byte-lane assembly, write strobe and address/count tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_lo       <= 8'd0;
            len          <= 16'd0;
            words_rcvd   <= 16'd0;
            lane         <= 2'd0;
            word_buf     <= 24'd0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            words_loaded <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (imem_we) begin
                words_loaded <= words_loaded + 16'd1;
                if (imem_addr != ADDR_W'(WORDS - 1)) begin
                    imem_addr <= imem_addr + ADDR_W'(1);
                end
            end
            if (restart) begin
                imem_addr    <= '0;
                words_loaded <= 16'd0;
                words_rcvd   <= 16'd0;
                lane         <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                csum         <= 8'd0;
`endif
            end
            if (accept) begin
                case (state)
                    LEN0: len_lo <= rx_data;
                    LEN1: len    <= len_full;
                    DATA: begin
                        lane <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        case (lane)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                imem_wdata <= {rx_data, word_buf};
                                imem_we    <= 1'b1;
                                words_rcvd <= words_rcvd + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter WORDS, default 256, meaning the instruction-memory depth in 32-bit words and the maximum accepted load length.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the imem_addr width, with 2^ADDR_W >= WORDS.
REQ-003 SHALL have port clk  in  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port start  in  1  single-cycle request to begin a load.
REQ-006 SHALL have port rx_data  in  8  incoming byte stream.
REQ-007 SHALL have port rx_valid  in  1  rx_data valid.
REQ-008 SHALL have port rx_ready  out  1  loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we  out  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  out  ADDR_W  word address of the write.
REQ-011 SHALL have port imem_wdata  out  32  instruction word to write.
REQ-012 SHALL have port core_reset  out  1  high holds the downstream core in reset.
REQ-013 SHALL have ports busy, done, err  out  1 each  load in progress, load succeeded, load failed.
REQ-014 SHALL have port words_loaded  out  16  count of words written in the current load.

Function
REQ-015 SHALL implement FSM states IDLE, LEN0, LEN1, DATA, WAIT, CSUM, DONE and ERROR.
REQ-016 SHALL accept a byte only on a rising edge with rx_valid=1 and rx_ready=1, and SHALL ignore rx_valid in every other cycle.
REQ-017 SHALL drive rx_ready=1 only in LEN0, LEN1, DATA and CSUM.
REQ-018 SHALL move IDLE->LEN0 when start=1, and SHALL ignore start while busy=1.
REQ-019 SHALL restart from DONE or ERROR on start=1, clearing done, err and words_loaded and asserting core_reset=1 on that edge.
REQ-020 SHALL form length N from the byte accepted in LEN0 as N[7:0] and the byte accepted in LEN1 as N[15:8].
REQ-021 SHALL move LEN1->ERROR when N > WORDS, performing no writes.
REQ-022 SHALL move LEN1->DONE when N=0 (or ->CSUM when LOADER_CHECKSUM_EN is defined).
REQ-023 SHALL move LEN1->DATA in all other cases.
REQ-024 SHALL assemble DATA bytes little-endian, with the first byte of each word in [7:0] and the fourth in [31:24].
REQ-025 SHALL assert imem_we for exactly one cycle, with registered imem_addr and imem_wdata, in the cycle after the edge that accepted the fourth byte of a word.
REQ-026 SHALL increment imem_addr and words_loaded on that write cycle's closing edge, with imem_addr starting at 0.
REQ-027 SHALL continue accepting bytes of the next word in DATA during a write cycle, so back-to-back bytes lose no throughput.
REQ-028 SHALL enter WAIT after the last payload byte of word N is accepted, with rx_ready=0 and the final imem_we asserted in WAIT.
REQ-029 SHALL move WAIT->DONE (or ->CSUM when LOADER_CHECKSUM_EN is defined) on the next edge, so done rises one cycle after the last imem_we.
REQ-030 SHALL drive core_reset=0 only in DONE, and SHALL hold core_reset=1 in every other state, ERROR included.
REQ-031 SHALL drive busy=1 in LEN0, LEN1, DATA, WAIT and CSUM.
REQ-032 SHALL drive done=1 only in DONE and err=1 only in ERROR.
REQ-033 SHALL never let imem_addr exceed WORDS-1 and SHALL perform no wrap-around write.

Reset
REQ-034 SHALL, on any edge with reset=0 including mid-load, enter IDLE and set rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, busy=0, done=0, err=0, words_loaded=0 and clear the byte lane counter and checksum.
REQ-035 SHALL let reset=0 override a simultaneous start=1 or byte acceptance.

Configuration
REQ-036 SHALL, when LOADER_CHECKSUM_EN is defined, keep a running XOR of all payload bytes and accept one trailer byte in CSUM.
REQ-037 SHALL, with LOADER_CHECKSUM_EN defined, move CSUM->DONE on a trailer match and CSUM->ERROR on a mismatch, with the N=0 expected value being 0x00.
REQ-038 SHALL, without LOADER_CHECKSUM_EN, contain no CSUM state or XOR logic and transition directly to DONE.

Verification
REQ-039 SHALL pass: stream 01 00 13 05 10 00 -> one imem_we, addr 0, wdata 0x00100513; next cycle done=1, core_reset=0, words_loaded=1.
REQ-040 SHALL pass: N=3 with rx_valid idle gaps of 0-3 cycles between bytes -> writes at addr 0,1,2 with correct words; no extra imem_we; done one cycle after the third write.
REQ-041 SHALL pass: stream 00 00 (no checksum) -> zero imem_we pulses; done=1 on the edge after LEN1.
REQ-042 SHALL pass: stream 01 01 (N=257, WORDS=256) -> err=1, core_reset=1, no imem_we; a later start with a valid stream loads normally.
REQ-043 SHALL pass: reset=0 for one cycle after two words of N=4 -> all outputs at REQ-034 values next cycle; a new start reloads from addr 0.
REQ-044 SHALL pass, with LOADER_CHECKSUM_EN defined: payload 13 05 10 00 with trailer 0x06 -> done=1; with trailer 0x07 -> err=1, core_reset=1.
